// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush, MDU freeze, EX forwarding select
// and saturating stall-cycle counter for a 5-stage RV32 pipeline.
module hazard_controller #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]  ex_rs1,
    input  logic [REG_ADDR_W-1:0]  ex_rs2,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    input  logic                   ex_mdu_start,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic                   mem_reg_write,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   wb_reg_write,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   mdu_done,
    output logic [STALL_CNT_W-1:0] stall_count
);
    typedef enum logic {RUN, MDU_BUSY} state_t;

    localparam logic [7:0] CNT_INIT = 8'(MDU_LATENCY - 2);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic                   load_use;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (mem_reg_write && mem_rd != '0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != '0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        load_use = ex_mem_read && ex_rd != '0 &&
                   ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_if = 1'b0;
        stall_id = 1'b0;
        stall_ex = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        mdu_done = 1'b0;
        if (state_q == MDU_BUSY) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
            mdu_done = cnt_q == 8'd0;
            state_d  = cnt_q == 8'd0 ? RUN : MDU_BUSY;
            cnt_d    = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
        end else if (ex_mdu_start) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
            cnt_d    = CNT_INIT;
            state_d  = MDU_BUSY;
        end else if (ex_branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
        // controls must read 0 while reset is held, whatever the inputs do
        if (!rst_n) begin
            stall_if = 1'b0;
            stall_id = 1'b0;
            stall_ex = 1'b0;
            flush_id = 1'b0;
            flush_ex = 1'b0;
            mdu_done = 1'b0;
        end
        stall_count_d = stall_count_q +
                        {{(STALL_CNT_W-1){1'b0}}, stall_if & ~(&stall_count_q)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 8'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign forward_a   = fwd_sel(ex_rs1);
    assign forward_b   = fwd_sel(ex_rs2);
    assign stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed and random stimulus against a cycle-level
// reference model; a second instance with a 4-bit counter covers saturation.
module tb_hazard_controller;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mdu_start;
    logic       mem_reg_write, wb_reg_write;
    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_done;
    logic       s_stall_if, s_stall_id, s_stall_ex, s_flush_id, s_flush_ex, s_mdu_done;
    logic [1:0] forward_a, forward_b, s_forward_a, s_forward_b;
    logic [15:0] stall_count;
    logic [3:0]  s_stall_count;

    int total = 0;
    int passed = 0;
    int busy_left = 0;
    int cnt_m = 0;
    int cnt_s = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_ADDR_W(5), .MDU_LATENCY(LAT), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .flush_id(flush_id), .flush_ex(flush_ex), .forward_a(forward_a),
        .forward_b(forward_b), .mdu_done(mdu_done), .stall_count(stall_count));

    hazard_controller #(.REG_ADDR_W(5), .MDU_LATENCY(LAT), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .stall_if(s_stall_if), .stall_id(s_stall_id),
        .stall_ex(s_stall_ex), .flush_id(s_flush_id), .flush_ex(s_flush_ex),
        .forward_a(s_forward_a), .forward_b(s_forward_b), .mdu_done(s_mdu_done),
        .stall_count(s_stall_count));

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mdu_start} = '0;
        {mem_reg_write, wb_reg_write} = '0;
    endtask

    // Checks combinational outputs mid-cycle, then advances the model on the edge.
    task automatic cycle();
        logic       lu;
        logic [5:0] e;
        @(negedge clk);
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (!rst_n)              e = 6'b000000;
        else if (busy_left > 0)  e = {5'b11100, busy_left == 1};
        else if (ex_mdu_start)   e = 6'b111000;
        else if (ex_branch_taken) e = 6'b000110;
        else if (lu)             e = 6'b110010;
        else                     e = 6'b000000;
        chk("ctrl", {stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_done}, e);
        chk("ctrl_sat", {s_stall_if, s_stall_id, s_stall_ex, s_flush_id, s_flush_ex, s_mdu_done}, e);
        chk("fwd", {forward_a, forward_b}, {fwd_ref(ex_rs1), fwd_ref(ex_rs2)});
        chk("stall_count", stall_count, cnt_m);
        chk("stall_count_sat", s_stall_count, cnt_s);
        @(posedge clk);
        if (rst_n) begin
            if (e[5]) begin
                cnt_m = cnt_m < 65535 ? cnt_m + 1 : cnt_m;
                cnt_s = cnt_s < 15 ? cnt_s + 1 : cnt_s;
            end
            if (busy_left > 0) busy_left--;
            else if (ex_mdu_start) busy_left = LAT - 1;
        end
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        busy_left = 0;
        cnt_m = 0;
        cnt_s = 0;
    endtask

    initial begin
        idle();
        assert_reset();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        cycle();
        idle();
        cycle();
        rst_n = 1'b1;
        cycle();
        // load-use, one stall cycle, then clear
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        cycle();
        idle();
        cycle();
        // load to x0, and load whose operand is unused
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        cycle();
        ex_rd = 6; id_rs1 = 6; id_uses_rs1 = 0; id_rs2 = 6; id_uses_rs2 = 0;
        cycle();
        id_uses_rs2 = 1;
        cycle();
        // branch coincident with load-use
        ex_branch_taken = 1;
        cycle();
        idle();
        // MDU op with a branch at T+1 that must be ignored
        ex_mdu_start = 1;
        cycle();
        ex_mdu_start = 0; ex_branch_taken = 1;
        cycle();
        ex_branch_taken = 0; ex_mdu_start = 1;
        cycle();
        ex_mdu_start = 0;
        cycle();
        cycle();
        // forwarding priority and x0
        mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_reg_write = 1; wb_reg_write = 1;
        cycle();
        mem_reg_write = 0;
        cycle();
        mem_rd = 0; wb_rd = 0; ex_rs2 = 0; mem_reg_write = 1; ex_rs1 = 3;
        cycle();
        idle();
        // reset asserted at T+2 of an MDU op
        ex_mdu_start = 1;
        cycle();
        ex_mdu_start = 0;
        cycle();
        assert_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        // 20 held load-use cycles drive the 4-bit counter into saturation
        ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
        repeat (20) cycle();
        idle();
        cycle();
        chk("sat_final", s_stall_count, 4'd15);
        // random traffic on a narrow register range to provoke matches
        repeat (400) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3));
            ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom);
            id_uses_rs2 = 1'($urandom);
            ex_mem_read = 1'($urandom);
            mem_reg_write = 1'($urandom);
            wb_reg_write = 1'($urandom);
            ex_branch_taken = $urandom_range(0, 3) == 0;
            ex_mdu_start = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 99) == 0) assert_reset();
            else rst_n = 1'b1;
            cycle();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Detects load-use hazards and inserts bubbles.
- Flushes wrong-path instructions on taken branches/jumps resolved in EX.
- Freezes IF/ID/EX while a multi-cycle MUL/DIV unit (MDU) occupies EX.
- Selects EX operand forwarding sources; counts stall cycles for performance monitoring.

Parameters:
REG_ADDR_W, 5, register index width
MDU_LATENCY, 4, total EX-occupancy cycles of an MDU op; legal range 2..255
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rs1  in  REG_ADDR_W  rs1 index of instruction in EX
ex_rs2  in  REG_ADDR_W  rs2 index of instruction in EX
ex_rd  in  REG_ADDR_W  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX redirects PC (taken branch, JAL, JALR)
ex_mdu_start  in  1  EX instruction is an MDU op
mem_rd  in  REG_ADDR_W  destination in MEM
mem_reg_write  in  1  MEM instruction writes rd
wb_rd  in  REG_ADDR_W  destination in WB
wb_reg_write  in  1  WB instruction writes rd
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
flush_id  out  1  zero IF/ID register (NOP)
flush_ex  out  1  zero ID/EX register (bubble)
forward_a  out  2  EX operand A source: 00 regfile, 10 MEM, 01 WB
forward_b  out  2  EX operand B source, same encoding
mdu_done  out  1  pulse in last MDU occupancy cycle
stall_count  out  STALL_CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- State: FSM {RUN, MDU_BUSY}, 8-bit down-counter cnt, stall_count register. Reset (async, rst_n=0): RUN, cnt=0, stall_count=0. All control outputs derive from state and inputs, so they read 0 during reset; forward_a/b stay combinational on the inputs.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, priority high to low:
  1. ex_mdu_start: stall_if=stall_id=stall_ex=1, no flush; cnt<=MDU_LATENCY-2; next MDU_BUSY.
  2. ex_branch_taken: flush_id=flush_ex=1, all stalls 0. Flush overrides a coincident load_use.
  3. load_use: stall_if=stall_id=1, flush_ex=1, stall_ex=0. Stalls exactly one cycle, because the load advances to MEM.
  4. Otherwise: all stall/flush 0.
- MDU_BUSY:
  - stall_if=stall_id=stall_ex=1, flushes 0.
  - ex_branch_taken, ex_mdu_start and load_use are ignored, since the EX content is frozen.
  - cnt==0: mdu_done=1; next RUN. Otherwise cnt<=cnt-1.
  - Total stall cycles per MDU op = MDU_LATENCY (start cycle plus MDU_LATENCY-1 busy cycles); the op leaves EX on the next edge.
  - MDU_LATENCY=2: a single MDU_BUSY cycle with mdu_done=1.
- Forwarding (combinational, state-independent), per operand with ex_rsX:
  - 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rsX.
  - else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rsX.
  - else 00.
  - MEM wins when both match.
- stall_count: increments each clock edge where stall_if=1. Saturates at all-ones and never wraps.
- Reset asserted mid-MDU_BUSY: stalls drop immediately. Stalls stay 0 after deassert until a new trigger.
- x0 never causes a hazard or forwarding.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of stall_if=stall_id=flush_ex=1. Next cycle (ex_mem_read=0) all 0. stall_count=1.
- Load to x0 or unused operand: ex_rd=0, id_rs1=0 (or id_uses_rs1=0) → no stall, no flush.
- Branch and load-use in the same cycle: ex_branch_taken=1 with load_use true → flush_id=flush_ex=1, stall_if=0.
- MDU, MDU_LATENCY=4: ex_mdu_start pulse at T → stall_if/id/ex=1 for T..T+3. mdu_done=1 only at T+3. ex_branch_taken=1 at T+1 ignored. RUN at T+4. stall_count=4.
- Forwarding: mem_rd=wb_rd=ex_rs1=7, both writing → forward_a=10. With mem_reg_write=0 → 01. With ex_rs2=0 and matching x0 writers → forward_b=00.
- Reset at T+2 of an MDU op → stalls 0 during reset; after release state RUN, stall_count=0. Saturation check with STALL_CNT_W=4 and 20 stall cycles → stall_count=15.
